dffn_pipe_adder: RTL and testbench

//   Parametrised, stallable multi-stage adder pipeline for the dffn app-level register-stress tests.

---
 rtl/dffn_pipe_adder_if.sv | 22 ++
 rtl/dffn_pipe_adder.sv | 106 ++++++++++
 tb/tb_dffn_pipe_adder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dffn_pipe_adder_if.sv
// Handshake bundle for dffn_pipe_adder: sample input port, result output port and occupancy.
interface dffn_pipe_adder_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
);
  localparam int CW = $clog2(DEPTH + 2);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [CW-1:0]    inflight;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, sum, ovf, inflight);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, sum, ovf, inflight);
endinterface

// File: rtl/dffn_pipe_adder.sv
// Stallable DEPTH-stage adder pipeline: stage 0 adds a+b, later stages alternately add a/b copies.
// Define DFFN_OVF_FLAG_EN to carry a sticky per-sample carry-out flag to the ovf output.
module dffn_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  dffn_pipe_adder_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 2);

  logic                        adv, acc_in, take;
  logic [DEPTH:0]              vld_q, vld_d;  // [DEPTH] is the output register
  logic [DEPTH-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [DEPTH-1:0][WIDTH-1:0] opa_q, opa_d;
  logic [DEPTH-1:0][WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0]            sum_q;
  logic [CW-1:0]               cnt_q, cnt_d;

  // One global enable: bubbles move with the samples, nothing compresses.
  assign adv    = !vld_q[DEPTH] || bus.out_ready;
  assign acc_in = bus.in_valid && adv;
  assign take   = vld_q[DEPTH] && bus.out_ready;

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[DEPTH];
  assign bus.sum       = sum_q;
  assign bus.inflight  = cnt_q;

`ifdef DFFN_OVF_FLAG_EN
  logic [DEPTH-1:0] ovf_q, ovf_d;
  logic             ovfo_q;
  logic [WIDTH:0]   wide;
`endif

  always_comb begin
    vld_d = {vld_q[DEPTH-1:0], bus.in_valid};
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    opa_d[0] = bus.a;
    opb_d[0] = bus.b;
`ifdef DFFN_OVF_FLAG_EN
    ovf_d    = ovf_q;
    wide     = {1'b0, bus.a} + {1'b0, bus.b};
    acc_d[0] = wide[WIDTH-1:0];
    ovf_d[0] = wide[WIDTH];
`else
    acc_d[0] = bus.a + bus.b;
`endif
    for (int k = 1; k < DEPTH; k++) begin
      opa_d[k] = opa_q[k-1];
      opb_d[k] = opb_q[k-1];
`ifdef DFFN_OVF_FLAG_EN
      wide     = {1'b0, acc_q[k-1]} + {1'b0, (k % 2 == 1) ? opa_q[k-1] : opb_q[k-1]};
      acc_d[k] = wide[WIDTH-1:0];
      ovf_d[k] = ovf_q[k-1] | wide[WIDTH];
`else
      acc_d[k] = acc_q[k-1] + ((k % 2 == 1) ? opa_q[k-1] : opb_q[k-1]);
`endif
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (acc_in && !take)      cnt_d = cnt_q + CW'(1);
    else if (!acc_in && take) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        vld_q <= vld_d;
        acc_q <= acc_d;
        opa_q <= opa_d;
        opb_q <= opb_d;
        sum_q <= acc_q[DEPTH-1];
      end
    end
  end

`ifdef DFFN_OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= '0;
      ovfo_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      ovfo_q <= ovf_q[DEPTH-1];
    end
  end
  assign bus.ovf = ovfo_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dffn_pipe_adder.sv
// Bench for dffn_pipe_adder: directed vectors on a DEPTH=10 and a DEPTH=2 instance plus a
// negedge scoreboard that predicts every result from the closed-form sum of the sample.
module tb_dffn_pipe_adder;
  typedef struct {
    logic [31:0] s;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;
  exp_t qa[$];
  exp_t qb[$];

  dffn_pipe_adder_if #(.WIDTH(32), .DEPTH(10)) ifa ();
  dffn_pipe_adder_if #(.WIDTH(32), .DEPTH(2))  ifb ();

  dffn_pipe_adder #(.WIDTH(32), .DEPTH(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  dffn_pipe_adder #(.WIDTH(32), .DEPTH(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Closed form: the true (unbounded) total crosses 2^32 exactly when some stage carried out.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input int d);
    logic [63:0] t;
    exp_t        e;
    t   = {32'b0, av} * 64'(1 + d / 2) + {32'b0, bv} * 64'(1 + (d - 1) / 2);
    e.s = t[31:0];
`ifdef DFFN_OVF_FLAG_EN
    e.o = (t[63:32] != 0);
`else
    e.o = 1'b0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_a_out_valid", ifa.out_valid, 0);
      chk("rst_a_inflight", ifa.inflight, 0);
      chk("rst_a_sum", ifa.sum, 0);
      chk("rst_a_ovf", ifa.ovf, 0);
      chk("rst_a_in_ready", ifa.in_ready, 1);
      chk("rst_b_out_valid", ifb.out_valid, 0);
      qa.delete();
      qb.delete();
    end else begin
      chk("sb_a_inflight", ifa.inflight, qa.size());
      chk("sb_a_in_ready", ifa.in_ready, !ifa.out_valid || ifa.out_ready);
      if (ifa.out_valid) begin
        if (qa.size() == 0) chk("sb_a_unexpected_out", 1, 0);
        else begin
          chk("sb_a_sum", ifa.sum, qa[0].s);
          chk("sb_a_ovf", ifa.ovf, qa[0].o);
          if (ifa.out_ready) void'(qa.pop_front());
        end
      end
      if (ifa.in_valid && ifa.in_ready) qa.push_back(model(ifa.a, ifa.b, 10));

      chk("sb_b_inflight", ifb.inflight, qb.size());
      if (ifb.out_valid) begin
        if (qb.size() == 0) chk("sb_b_unexpected_out", 1, 0);
        else begin
          chk("sb_b_sum", ifb.sum, qb[0].s);
          if (ifb.out_ready) void'(qb.pop_front());
        end
      end
      if (ifb.in_valid && ifb.in_ready) qb.push_back(model(ifb.a, ifb.b, 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one sample on the DEPTH=10 instance and waits (bounded) for its result.
  task automatic one_a(input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output logic [31:0] s, output logic o);
    ifa.in_valid = 1'b1; ifa.a = av; ifa.b = bv; ifa.out_ready = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    lat = 1;
    while (!ifa.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    s = ifa.sum;
    o = ifa.ovf;
    tick();
  endtask

  initial begin
    int          lat, n_out, first, last, nacc, n, guard;
    logic [31:0] s, held;
    logic        o, seen;
    logic [31:0] exp3[$];

    ifa.in_valid = 0; ifa.a = 0; ifa.b = 0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.a = 0; ifb.b = 0; ifb.out_ready = 1;
    repeat (3) tick();
    chk("reset_out_valid", ifa.out_valid, 0);
    chk("reset_inflight", ifa.inflight, 0);
    chk("reset_in_ready", ifa.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // 1: single sample
    one_a(32'd1, 32'd2, lat, s, o);
    chk("t1_latency", lat, 11);
    chk("t1_sum", s, 16);
    chk("t1_ovf", o, 0);
    chk("t1_inflight_end", ifa.inflight, 0);

    // 2: 20 back-to-back samples
    n_out = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) begin
        ifa.in_valid = 1'b1; ifa.a = 32'(c + 1); ifa.b = 32'(2 * (c + 1));
      end else ifa.in_valid = 1'b0;
      tick();
      chk("t2_in_ready", ifa.in_ready, 1);
      if (ifa.out_valid) begin
        chk("t2_sum", ifa.sum, 64'(16 * (n_out + 1)));
        if (n_out == 0) first = c;
        last = c;
        n_out++;
      end
    end
    chk("t2_count", n_out, 20);
    chk("t2_one_per_cycle", last - first, 19);

    // 3: backpressure for 15 cycles, then drain
    ifa.out_ready = 1'b0; nacc = 0; seen = 1'b0; held = '0;
    for (int c = 0; c < 15; c++) begin
      ifa.in_valid = 1'b1; ifa.a = 32'(100 + c); ifa.b = 32'(c);
      if (ifa.in_ready) begin
        exp3.push_back(32'(600 + 11 * c));
        nacc++;
      end
      tick();
      if (ifa.out_valid) begin
        if (!seen) begin held = ifa.sum; seen = 1'b1; end
        else chk("t3_sum_held", ifa.sum, held);
      end
    end
    chk("t3_inflight_full", ifa.inflight, 11);
    chk("t3_in_ready_low", ifa.in_ready, 0);
    chk("t3_accepted", nacc, 11);
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; n = 0; guard = 0;
    while (n < 11 && guard < 40) begin
      if (ifa.out_valid) begin
        chk("t3_drain_sum", ifa.sum, (n < exp3.size()) ? exp3[n] : 32'hx);
        n++;
      end
      tick();
      guard++;
    end
    chk("t3_drained", n, 11);
    chk("t3_inflight_end", ifa.inflight, 0);

    // 4: overflow
    one_a(32'hFFFF_FFFF, 32'd1, lat, s, o);
    chk("t4_sum", s, 32'hFFFF_FFFF);
`ifdef DFFN_OVF_FLAG_EN
    chk("t4_ovf", o, 1);
`else
    chk("t4_ovf", o, 0);
`endif

    // 5: reset with 5 samples in flight
    ifa.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ifa.in_valid = 1'b1; ifa.a = 32'(c + 1); ifa.b = 32'(c + 1);
      tick();
    end
    ifa.in_valid = 1'b0;
    repeat (12) tick();
    chk("t5_pre_out_valid", ifa.out_valid, 1);
    chk("t5_pre_inflight", ifa.inflight, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_out_valid", ifa.out_valid, 0);
    chk("t5_async_inflight", ifa.inflight, 0);
    chk("t5_async_sum", ifa.sum, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    one_a(32'd3, 32'd0, lat, s, o);
    chk("t5_fresh_latency", lat, 11);
    chk("t5_fresh_sum", s, 18);

    // 6: DEPTH=2 instance
    ifb.in_valid = 1'b1; ifb.a = 32'd5; ifb.b = 32'd7;
    tick();
    ifb.in_valid = 1'b0;
    lat = 1;
    while (!ifb.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6_latency", lat, 3);
    chk("t6_sum", ifb.sum, 17);
    tick();
    chk("t6_inflight_end", ifb.inflight, 0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
